fft_bitrev_loader: RTL and testbench
====================================

Name: fft_bitrev_loader

Overview:
- Input stage of the 8-point radix-2 DIT FFT, directly upstream of the stage-1 butterflies.
- Accepts a stream of 8 complex Q8 samples over a valid/ready handshake.
- Stores each sample at its bit-reversed address.
- Issues the 4 stage-1 operand pairs, with the W8^0 twiddle and a start strobe, on 4 consecutive cycles in the form the butterfly consumes.

Parameters:
- DATA_W, 16, signed width of each real/imag component.
- TW_ONE, 256, Q8 encoding of twiddle 1.0. Matches the butterfly's >>8 scaling.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  sample presented.
- in_ready  out  1  block can accept a sample.
- in_r  in  DATA_W  sample real, signed.
- in_i  in  DATA_W  sample imag, signed.
- start  out  1  operand pair valid. Drives butterfly start.
- x1_r, x1_i  out  DATA_W each  upper operand (even bit-reversed slot).
- x2_r, x2_i  out  DATA_W each  lower operand (odd bit-reversed slot).
- w_r, w_i  out  DATA_W each  twiddle. Stage 1 always (TW_ONE, 0).
- pair_idx  out  2  index of the pair currently issued, 0..3.
- frame_last  out  1  high with start on pair 3 only.

Behaviour:
- Reset:
  - State LOAD, sample counter 0.
  - in_ready=1 (registered, valid the cycle after rst deasserts).
  - start=0, frame_last=0, pair_idx=0.
  - All data and twiddle outputs 0.
  - Buffer contents are don't-care.
- All outputs are registered. Outputs are forced to 0 whenever start=0, matching the butterfly's idle convention.
- Handshake: a sample is accepted on a rising edge where in_valid && in_ready.
  - Accepted sample k (k = 0..7, arrival order) is written to buf[bitrev3(k)].
  - bitrev3: 0→0, 1→4, 2→2, 3→6, 4→1, 5→5, 6→3, 7→7.
- State LOAD:
  - in_ready=1; the counter increments per accept.
  - The edge accepting sample 7 moves to ISSUE, loads pair 0 into the output registers, and drops in_ready.
  - Gaps in in_valid are allowed; the counter holds.
- State ISSUE: 4 cycles with start=1, one per pair.
  - Pair p is x1 = buf[2p], x2 = buf[2p+1].
  - Pairs: p0 = (x0, x4), p1 = (x2, x6), p2 = (x1, x5), p3 = (x3, x7).
  - w = (TW_ONE, 0) for every pair; pair_idx = p.
  - After the edge that ends pair 3: state LOAD, start=0, outputs 0, in_ready=1, counter 0.
- Latency: the first start cycle begins immediately after the edge accepting sample 7.
- No backpressure on the output side; the butterfly always consumes.
- in_valid while in_ready=0: ignored, sample not consumed.
- Reset mid-LOAD or mid-ISSUE: the partial frame is discarded and the next edge gives reset values. No partial pairs are emitted.
- Arithmetic: none. Pure storage and routing, no width change, sign preserved.

Optional Feature:
- FFT_LOADER_DBUF_EN
- Defined:
  - Two banks, ping-pong. in_ready stays 1 at all times after reset.
  - Loading frame n+1 into the alternate bank proceeds while frame n issues.
  - Frame completion swaps banks and starts issue from the just-filled bank.
  - A frame cannot complete while the previous issue is in progress, since 8 accepts take ≥8 cycles and issue takes 4.
  - Back-to-back full-rate frames give start high 4 of every 8 cycles.
- Undefined: single bank with in_ready=0 during ISSUE, as above.

Decomposition:
- Package fft_pkg holds:
  - DATA_W, N=8, LOG2N=3, TW_ONE=256.
  - bitrev3 function.
  - State enum {LOAD, ISSUE}.
  - Stage-1 twiddle constants.
- Single module. No sub-module is needed; bit reversal is a package function.

Test Plan:
- Reset then samples re=1..8, im=0 at full rate → start high 4 cycles from the edge after sample 8.
  - Pairs in order: (1,5), (3,7), (2,6), (4,8).
  - w=(256,0) throughout; pair_idx 0..3; frame_last on the 4th cycle only.
- Random in_valid gaps (e.g. valid 1-0-0-1…) with values −8..−1 → identical pair ordering; no start until the 8th accept.
- in_valid held high during ISSUE (single bank) → in_ready=0 for exactly 4 cycles, no sample lost or duplicated. The next frame's first value lands in p0.x1.
- rst asserted after 5 accepts, then a fresh 8-sample frame → no start before the new frame; outputs match the fresh frame only.
- rst asserted during pair 1 of ISSUE → start=0 and all outputs 0 on the following cycle; in_ready=1 afterwards.
- With FFT_LOADER_DBUF_EN: two back-to-back full-rate frames (1..8 then 9..16) → in_ready never low.
  - Second issue yields (9,13), (11,15), (10,14), (12,16) starting the cycle after sample 16.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants, state encoding and bit-reversal helper for the
// 8-point FFT input loader.
package fft_pkg;

   localparam int DATA_W = 16;
   localparam int N      = 8;
   localparam int LOG2N  = 3;
   localparam int TW_ONE = 256;

   // Stage-1 twiddle is W8^0 = 1.0 + j0 for every pair
   localparam int W1_R = TW_ONE;
   localparam int W1_I = 0;

   typedef enum logic {
      LOAD,
      ISSUE
   } state_t;

   function automatic logic [LOG2N-1:0] bitrev3(input logic [LOG2N-1:0] k);
      return {k[0], k[1], k[2]};
   endfunction

endpackage

// File: rtl/fft_bitrev_loader_if.sv
// Sample-in handshake and stage-1 operand bundle of the FFT loader.
interface fft_bitrev_loader_if
   import fft_pkg::*;
#(
   parameter int DATA_W = fft_pkg::DATA_W
) ();

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_r;
   logic [DATA_W-1:0] in_i;
   logic              start;
   logic [DATA_W-1:0] x1_r;
   logic [DATA_W-1:0] x1_i;
   logic [DATA_W-1:0] x2_r;
   logic [DATA_W-1:0] x2_i;
   logic [DATA_W-1:0] w_r;
   logic [DATA_W-1:0] w_i;
   logic [1:0]        pair_idx;
   logic              frame_last;

   modport master (
      output in_valid, in_r, in_i,
      input  in_ready, start, x1_r, x1_i, x2_r, x2_i,
      input  w_r, w_i, pair_idx, frame_last
   );

   modport slave (
      input  in_valid, in_r, in_i,
      output in_ready, start, x1_r, x1_i, x2_r, x2_i,
      output w_r, w_i, pair_idx, frame_last
   );

endinterface

// File: rtl/fft_bitrev_loader.sv
// Bit-reversed sample loader feeding the stage-1 butterflies.
// Define FFT_LOADER_DBUF_EN for ping-pong banks (load while issuing).
module fft_bitrev_loader
   import fft_pkg::*;
#(
   parameter int DATA_W = fft_pkg::DATA_W,
   parameter int TW_ONE = fft_pkg::TW_ONE
) (
   input  logic          clk,
   input  logic          rst,
   fft_bitrev_loader_if.slave bus
);

`ifdef FFT_LOADER_DBUF_EN
   localparam logic DBUF = 1'b1;
`else
   localparam logic DBUF = 1'b0;
`endif

   logic [DATA_W-1:0] mem_r [2][N];
   logic [DATA_W-1:0] mem_i [2][N];

   state_t            state_q, state_d;
   logic [LOG2N-1:0]  cnt_q, cnt_d;
   logic [1:0]        pair_q, pair_d;
   logic              rdy_q, rdy_d;
   logic              start_q, start_d;
   logic              last_q, last_d;
   logic              wr_bank_q, wr_bank_d;
   logic              rd_bank_q, rd_bank_d;
   logic [DATA_W-1:0] x1r_q, x1r_d;
   logic [DATA_W-1:0] x1i_q, x1i_d;
   logic [DATA_W-1:0] x2r_q, x2r_d;
   logic [DATA_W-1:0] x2i_q, x2i_d;
   logic [DATA_W-1:0] wr_q, wr_d;
   logic [DATA_W-1:0] wi_q, wi_d;
   logic              acc;
   logic              issue;

   assign acc = bus.in_valid && rdy_q;

   always_ff @(posedge clk) begin
      if (acc) begin
         mem_r[wr_bank_q][bitrev3(cnt_q)] <= bus.in_r;
         mem_i[wr_bank_q][bitrev3(cnt_q)] <= bus.in_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= LOAD;
         cnt_q     <= '0;
         pair_q    <= '0;
         rdy_q     <= 1'b1;
         start_q   <= 1'b0;
         last_q    <= 1'b0;
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
         x1r_q     <= '0;
         x1i_q     <= '0;
         x2r_q     <= '0;
         x2i_q     <= '0;
         wr_q      <= '0;
         wi_q      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pair_q    <= pair_d;
         rdy_q     <= rdy_d;
         start_q   <= start_d;
         last_q    <= last_d;
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         x1r_q     <= x1r_d;
         x1i_q     <= x1i_d;
         x2r_q     <= x2r_d;
         x2i_q     <= x2i_d;
         wr_q      <= wr_d;
         wi_q      <= wi_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pair_d    = pair_q;
      rdy_d     = rdy_q;
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      issue     = 1'b0;
      start_d   = 1'b0;
      last_d    = 1'b0;
      x1r_d     = '0;
      x1i_d     = '0;
      x2r_d     = '0;
      x2i_d     = '0;
      wr_d      = '0;
      wi_d      = '0;

      if (acc)
         cnt_d = cnt_q + 3'd1;

      case (state_q)
         LOAD: begin
            if (acc && cnt_q == 3'd7) begin
               state_d   = ISSUE;
               issue     = 1'b1;
               pair_d    = 2'd0;
               rd_bank_d = wr_bank_q;
               wr_bank_d = wr_bank_q ^ DBUF;
               rdy_d     = DBUF;
            end
         end
         ISSUE: begin
            if (pair_q == 2'd3) begin
               state_d = LOAD;
               pair_d  = 2'd0;
               rdy_d   = 1'b1;
            end else begin
               issue  = 1'b1;
               pair_d = pair_q + 2'd1;
            end
         end
         default: state_d = LOAD;
      endcase

      // Pair p reads the adjacent slots 2p/2p+1 of the issuing bank
      if (issue) begin
         start_d = 1'b1;
         last_d  = (pair_d == 2'd3);
         x1r_d   = mem_r[rd_bank_d][{pair_d, 1'b0}];
         x1i_d   = mem_i[rd_bank_d][{pair_d, 1'b0}];
         x2r_d   = mem_r[rd_bank_d][{pair_d, 1'b1}];
         x2i_d   = mem_i[rd_bank_d][{pair_d, 1'b1}];
         wr_d    = DATA_W'(TW_ONE);
         wi_d    = DATA_W'(W1_I);
      end
   end

   assign bus.in_ready   = rdy_q;
   assign bus.start      = start_q;
   assign bus.frame_last = last_q;
   assign bus.pair_idx   = pair_q;
   assign bus.x1_r       = x1r_q;
   assign bus.x1_i       = x1i_q;
   assign bus.x2_r       = x2r_q;
   assign bus.x2_i       = x2i_q;
   assign bus.w_r        = wr_q;
   assign bus.w_i        = wi_q;

endmodule

// File: tb/tb_fft_bitrev_loader.sv
// Randomized bench for fft_bitrev_loader against a queue-based
// frame/pair reference model.
module tb_fft_bitrev_loader;
   import fft_pkg::*;

`ifdef FFT_LOADER_DBUF_EN
   localparam bit DBUF = 1'b1;
`else
   localparam bit DBUF = 1'b0;
`endif

   typedef struct {
      bit st;
      int p;
      int x1r;
      int x1i;
      int x2r;
      int x2i;
   } pair_t;

   typedef struct {
      int r;
      int i;
   } smp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   fft_bitrev_loader_if bus ();

   fft_bitrev_loader dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int    rev [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
   smp_t  src [$];
   pair_t q [$];
   pair_t cur;
   smp_t  frame [8];
   int    cnt;
   bit    exp_rdy;
   int    checks;
   int    errors;

   task automatic check(input string tag,
                        input logic signed [31:0] got,
                        input logic signed [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_edge(input bit v, input bit r);
      bit acc;
      if (r) begin
         cnt     = 0;
         q.delete();
         cur     = '{default: 0};
         exp_rdy = 1'b1;
         return;
      end
      acc = v && exp_rdy;
      if (q.size() > 0) cur = q.pop_front();
      else cur = '{default: 0};
      if (acc) begin
         frame[cnt] = src.pop_front();
         cnt++;
         if (cnt == 8) begin
            cnt = 0;
            for (int p = 0; p < 4; p++)
               q.push_back('{1'b1, p,
                  frame[rev[2*p]].r, frame[rev[2*p]].i,
                  frame[rev[2*p+1]].r, frame[rev[2*p+1]].i});
            cur = q.pop_front();
         end
      end
      exp_rdy = DBUF || !cur.st;
   endtask

   task automatic compare_all();
      check("start", bus.start, cur.st);
      check("pair_idx", bus.pair_idx, cur.st ? cur.p : 0);
      check("frame_last", bus.frame_last, cur.st && cur.p == 3);
      check("x1_r", $signed(bus.x1_r), cur.x1r);
      check("x1_i", $signed(bus.x1_i), cur.x1i);
      check("x2_r", $signed(bus.x2_r), cur.x2r);
      check("x2_i", $signed(bus.x2_i), cur.x2i);
      check("w_r", $signed(bus.w_r), cur.st ? TW_ONE : 0);
      check("w_i", $signed(bus.w_i), 0);
      check("in_ready", bus.in_ready, exp_rdy);
   endtask

   task automatic cycle(input bit v, input bit r);
      rst          = r;
      bus.in_valid = v;
      if (src.size() > 0) begin
         bus.in_r = 16'(src[0].r);
         bus.in_i = 16'(src[0].i);
      end else begin
         bus.in_r = 16'($urandom);
         bus.in_i = 16'($urandom);
      end
      @(posedge clk);
      model_edge(v, r);
      @(negedge clk);
      compare_all();
   endtask

   function automatic bit pick(input int prob);
      return src.size() > 0 && $urandom_range(0, 99) < prob;
   endfunction

   task automatic run(input int prob, input int maxc);
      int n = 0;
      while ((src.size() > 0 || q.size() > 0 || cur.st) && n < maxc) begin
         cycle(pick(prob), 1'b0);
         n++;
      end
      check("drain", src.size() + q.size() + int'(cur.st), 0);
      cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b0);
   endtask

   task automatic push_rand();
      for (int k = 0; k < 8; k++)
         src.push_back('{int'($urandom_range(0, 65535)) - 32768,
                         int'($urandom_range(0, 65535)) - 32768});
   endtask

   initial begin
      int n;
      checks       = 0;
      errors       = 0;
      cnt          = 0;
      exp_rdy      = 1'b1;
      cur          = '{default: 0};
      bus.in_valid = 1'b0;
      bus.in_r     = '0;
      bus.in_i     = '0;

      repeat (3) cycle(1'b0, 1'b1);

      for (int k = 1; k <= 8; k++) src.push_back('{k, 0});
      run(100, 200);

      for (int k = -8; k <= -1; k++) src.push_back('{k, 3 * k});
      run(40, 400);

      push_rand();
      push_rand();
      run(100, 200);

      push_rand();
      n = 0;
      while (cnt < 5 && n < 100) begin
         cycle(pick(100), 1'b0);
         n++;
      end
      check("five_accepts", cnt, 5);
      src.delete();
      cycle(1'b0, 1'b1);
      push_rand();
      run(100, 200);

      push_rand();
      n = 0;
      while (!(cur.st && cur.p == 1) && n < 100) begin
         cycle(pick(100), 1'b0);
         n++;
      end
      check("reach_pair1", cur.p, 1);
      src.delete();
      cycle(1'b0, 1'b1);
      cycle(1'b0, 1'b0);
      for (int k = 1; k <= 16; k++) src.push_back('{k, -k});
      run(100, 200);

      for (int f = 0; f < 6; f++) push_rand();
      run(int'($urandom_range(30, 100)), 1000);

      for (int k = 1; k <= 16; k++) src.push_back('{k, 0});
      run(100, 200);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
